bbox_detector: RTL and testbench

//   Single-pass bounding-box finder for a raster-scanned binarised frame.
//   Row and column foreground projections are built while pixels stream in.

---
 rtl/bbox_detector.sv | 217 +++++++++++++++++++++
 tb/tb_bbox_detector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_detector.sv
// Single-pass bounding-box finder for a raster-scanned binarised frame.
// Row hits are tracked on the fly; column counts live in colmem and are scanned after the frame.
module bbox_detector #(
   parameter int unsigned IMG_W      = 640,
   parameter int unsigned IMG_H      = 480,
   parameter int unsigned CW         = 10,
   parameter int unsigned PIX_W      = 10,
   parameter int unsigned FG_VALUE   = 0,
   parameter int unsigned ROW_THRESH = 3,
   parameter int unsigned COL_THRESH = 3,
   parameter int unsigned MARGIN     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_pix_valid,
   input  logic             i_pix_sof,
   input  logic [PIX_W-1:0] i_pix_data,
   output logic             o_in_ready,
   output logic             o_box_valid,
   output logic             o_box_found,
   output logic [CW-1:0]    o_top,
   output logic [CW-1:0]    o_bottom,
   output logic [CW-1:0]    o_left,
   output logic [CW-1:0]    o_right,
   output logic             o_sync_err
);

   localparam int unsigned CNT_W = $clog2(IMG_H + 1);
   localparam int unsigned RS_W  = $clog2(IMG_W + 1);

   localparam logic [CW-1:0] LP_LAST_COL = CW'(IMG_W - 1);
   localparam logic [CW-1:0] LP_LAST_ROW = CW'(IMG_H - 1);
   localparam logic [CW:0]   LP_MARGIN   = (CW + 1)'(MARGIN);
   localparam logic [CW:0]   LP_MAX_ROW  = (CW + 1)'(IMG_H - 1);
   localparam logic [CW:0]   LP_MAX_COL  = (CW + 1)'(IMG_W - 1);

   typedef enum logic [2:0] {StClear, StIdle, StAccum, StScan, StDone} t_state;

   t_state            r_state;
   // Shared address: clear/scan pointer, and the current column while accumulating.
   logic [CW-1:0]     r_addr;
   logic [CW-1:0]     r_row;
   logic [RS_W-1:0]   r_row_sum;
   logic              r_row_hit;
   logic              r_col_hit;
   logic [CW-1:0]     r_top;
   logic [CW-1:0]     r_bot;
   logic [CW-1:0]     r_left;
   logic [CW-1:0]     r_right;
   logic [CNT_W-1:0]  r_colmem [IMG_W];

   logic              w_accept;
   logic              w_fg;
   logic [CNT_W-1:0]  w_rd;
   logic              w_mem_we;
   logic [CNT_W-1:0]  w_mem_wdata;
   logic [RS_W-1:0]   w_row_sum_nx;
   logic              w_row_end;
   logic              w_last;
   logic              w_row_hit_now;
   logic              w_col_hit_now;
   logic              w_col_any;
   logic [CW-1:0]     w_left_fin;
   logic [CW-1:0]     w_right_fin;
   logic [CW:0]       w_top_x;
   logic [CW:0]       w_left_x;
   logic [CW:0]       w_bot_x;
   logic [CW:0]       w_right_x;

   assign o_in_ready    = i_en & ((r_state == StIdle) | (r_state == StAccum));
   assign w_accept      = i_pix_valid & o_in_ready;
   assign w_fg          = (i_pix_data == PIX_W'(FG_VALUE));
   assign w_rd          = r_colmem[r_addr];
   assign w_row_sum_nx  = r_row_sum + RS_W'(w_fg);
   assign w_row_end     = (r_addr == LP_LAST_COL);
   assign w_last        = w_row_end & (r_row == LP_LAST_ROW);
   assign w_row_hit_now = (w_row_sum_nx > RS_W'(ROW_THRESH));
   assign w_col_hit_now = (w_rd > CNT_W'(COL_THRESH));

   // Final column edges include the address being scanned in the last SCAN cycle.
   assign w_col_any   = r_col_hit | w_col_hit_now;
   assign w_left_fin  = r_col_hit ? r_left : r_addr;
   assign w_right_fin = w_col_hit_now ? r_addr : r_right;

   assign w_top_x   = {1'b0, r_top};
   assign w_left_x  = {1'b0, w_left_fin};
   assign w_bot_x   = {1'b0, r_bot} + LP_MARGIN;
   assign w_right_x = {1'b0, w_right_fin} + LP_MARGIN;

   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_wdata = '0;
      if (i_en) begin
         case (r_state)
            StClear, StScan: w_mem_we = 1'b1;
            StIdle: begin
               if (w_accept && i_pix_sof && w_fg) begin
                  w_mem_we    = 1'b1;
                  w_mem_wdata = w_rd + 1'b1;
               end
            end
            StAccum: begin
               if (w_accept && !i_pix_sof && w_fg) begin
                  w_mem_we    = 1'b1;
                  w_mem_wdata = w_rd + 1'b1;
               end
            end
            default: w_mem_we = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) r_colmem[r_addr] <= w_mem_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StClear;
         r_addr      <= '0;
         r_row       <= '0;
         r_row_sum   <= '0;
         r_row_hit   <= 1'b0;
         r_col_hit   <= 1'b0;
         r_top       <= '0;
         r_bot       <= '0;
         r_left      <= '0;
         r_right     <= '0;
         o_box_valid <= 1'b0;
         o_box_found <= 1'b0;
         o_top       <= '0;
         o_bottom    <= '0;
         o_left      <= '0;
         o_right     <= '0;
         o_sync_err  <= 1'b0;
      end else begin
         o_box_valid <= 1'b0;
         o_sync_err  <= 1'b0;
         if (i_en) begin
            case (r_state)
               StClear: begin
                  if (r_addr == LP_LAST_COL) begin
                     r_addr  <= '0;
                     r_state <= StIdle;
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
               StIdle: begin
                  if (w_accept && i_pix_sof) begin
                     r_row     <= '0;
                     r_addr    <= CW'(1);
                     r_row_sum <= RS_W'(w_fg);
                     r_row_hit <= 1'b0;
                     r_col_hit <= 1'b0;
                     r_state   <= StAccum;
                  end
               end
               StAccum: begin
                  if (w_accept) begin
                     if (i_pix_sof) begin
                        o_sync_err <= 1'b1;
                        r_addr     <= '0;
                        r_state    <= StClear;
                     end else if (w_row_end) begin
                        r_row_sum <= '0;
                        r_addr    <= '0;
                        r_row     <= r_row + 1'b1;
                        if (w_row_hit_now) begin
                           if (!r_row_hit) r_top <= r_row;
                           r_bot     <= r_row;
                           r_row_hit <= 1'b1;
                        end
                        if (w_last) r_state <= StScan;
                     end else begin
                        r_row_sum <= w_row_sum_nx;
                        r_addr    <= r_addr + 1'b1;
                     end
                  end
               end
               StScan: begin
                  if (w_col_hit_now) begin
                     if (!r_col_hit) r_left <= r_addr;
                     r_right   <= r_addr;
                     r_col_hit <= 1'b1;
                  end
                  if (r_addr == LP_LAST_COL) begin
                     r_addr      <= '0;
                     r_state     <= StDone;
                     o_box_valid <= 1'b1;
                     if (r_row_hit && w_col_any) begin
                        o_box_found <= 1'b1;
                        o_top    <= (w_top_x >= LP_MARGIN) ? r_top - LP_MARGIN[CW-1:0] : '0;
                        o_left   <= (w_left_x >= LP_MARGIN) ? w_left_fin - LP_MARGIN[CW-1:0] : '0;
                        o_bottom <= (w_bot_x > LP_MAX_ROW) ? LP_MAX_ROW[CW-1:0] : w_bot_x[CW-1:0];
                        o_right  <= (w_right_x > LP_MAX_COL) ? LP_MAX_COL[CW-1:0]
                                                             : w_right_x[CW-1:0];
                     end else begin
                        o_box_found <= 1'b0;
                        o_top       <= '0;
                        o_bottom    <= '0;
                        o_left      <= '0;
                        o_right     <= '0;
                     end
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
               StDone:  r_state <= StIdle;
               default: r_state <= StClear;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bbox_detector.sv
// Randomized self-checking bench for bbox_detector on a 16x8 frame.
// Expected boxes come from a frame-level projection model over a pixel map.
module tb_bbox_detector;

   localparam int W = 16;
   localparam int H = 8;
   localparam int M = 1;
   localparam int TH = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b1;
   logic       pv = 1'b0;
   logic       sof = 1'b0;
   logic [9:0] pd = '0;
   logic       in_ready, box_valid, box_found, sync_err;
   logic [3:0] top, bottom, left, right;

   bit fg_map [H][W];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   bbox_detector #(
      .IMG_W(W), .IMG_H(H), .CW(4), .PIX_W(10), .FG_VALUE(0),
      .ROW_THRESH(TH), .COL_THRESH(TH), .MARGIN(M)
   ) u_dut (
      .clk(clk), .rst(rst), .i_en(en), .i_pix_valid(pv), .i_pix_sof(sof),
      .i_pix_data(pd), .o_in_ready(in_ready), .o_box_valid(box_valid),
      .o_box_found(box_found), .o_top(top), .o_bottom(bottom), .o_left(left),
      .o_right(right), .o_sync_err(sync_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] pix_val(input bit f);
      return f ? 10'd0 : 10'($urandom_range(1, 1023));
   endfunction

   task automatic clear_map();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) fg_map[y][x] = 1'b0;
   endtask

   task automatic set_rect(input int y0, input int y1, input int x0, input int x1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) fg_map[y][x] = 1'b1;
   endtask

   // Box from row/column projections of the whole frame.
   task automatic model_box(output bit f, output int t, output int b, output int l,
                            output int r);
      int ft = -1, lb = -1, fl = -1, lr = -1;
      for (int y = 0; y < H; y++) begin
         int c = 0;
         for (int x = 0; x < W; x++) c += int'(fg_map[y][x]);
         if (c > TH) begin
            if (ft < 0) ft = y;
            lb = y;
         end
      end
      for (int x = 0; x < W; x++) begin
         int c = 0;
         for (int y = 0; y < H; y++) c += int'(fg_map[y][x]);
         if (c > TH) begin
            if (fl < 0) fl = x;
            lr = x;
         end
      end
      f = (ft >= 0) && (fl >= 0);
      if (f) begin
         t = (ft - M < 0) ? 0 : ft - M;
         l = (fl - M < 0) ? 0 : fl - M;
         b = (lb + M > H - 1) ? H - 1 : lb + M;
         r = (lr + M > W - 1) ? W - 1 : lr + M;
      end else begin
         t = 0; b = 0; l = 0; r = 0;
      end
   endtask

   task automatic send_pix(input logic [9:0] d, input logic s, input bit rnd, output int t_acc);
      int n = 0;
      bit got = 1'b0;
      t_acc = -1;
      while (!got && n < 500) begin
         @(negedge clk);
         en  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         pv  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         pd  = d;
         sof = s;
         #1;
         if (en && pv && in_ready) begin
            got   = 1'b1;
            t_acc = cyc;
         end
         n++;
      end
      if (!got) check_eq("accept_timeout", 0, 1);
      else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input bit rnd, input int sof_at, input int n_pix, output int t_last);
      int t;
      logic s;
      t_last = -1;
      for (int i = 0; i < n_pix; i++) begin
         s = (i == 0) || (i == sof_at);
         send_pix(pix_val(fg_map[i / W][i % W]), s, rnd, t);
         t_last = t;
      end
      pv = 1'b0; sof = 1'b0; en = 1'b1;
   endtask

   task automatic wait_box(input int t_last, input string tag);
      int n = 0;
      bit f;
      int t, b, l, r;
      model_box(f, t, b, l, r);
      pv = 1'b0; sof = 1'b0; en = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!box_valid && n < 100);
      check_eq({tag, "_latency"}, cyc - t_last, W + 1);
      check_eq({tag, "_found"}, int'(box_found), int'(f));
      check_eq({tag, "_top"}, int'(top), t);
      check_eq({tag, "_bottom"}, int'(bottom), b);
      check_eq({tag, "_left"}, int'(left), l);
      check_eq({tag, "_right"}, int'(right), r);
      @(negedge clk);
      check_eq({tag, "_pulse"}, int'(box_valid), 0);
   endtask

   task automatic wait_ready(input string tag, input int exp_cycles);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, n, exp_cycles);
   endtask

   task automatic random_map();
      int y0, y1, x0, x1;
      clear_map();
      y0 = $urandom_range(0, H - 1); y1 = $urandom_range(y0, H - 1);
      x0 = $urandom_range(0, W - 1); x1 = $urandom_range(x0, W - 1);
      set_rect(y0, y1, x0, x1);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            if ($urandom_range(0, 29) == 0) fg_map[y][x] = 1'b1;
   endtask

   initial begin
      int tl;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", int'(in_ready), 0);
      check_eq("rst_valid", int'(box_valid), 0);
      check_eq("rst_found", int'(box_found), 0);
      check_eq("rst_coords", int'({top, bottom, left, right}), 0);
      check_eq("rst_sync", int'(sync_err), 0);
      rst = 1'b1;
      wait_ready("clear_len", 16);
      en = 1'b0;
      #1;
      check_eq("en_low_ready", int'(in_ready), 0);
      en = 1'b1;

      clear_map(); set_rect(2, 4, 5, 9);
      send_frame(1'b0, -1, W * H, tl);
      wait_box(tl, "c1");
      check_eq("c1_top_abs", int'(top), 1);
      check_eq("c1_right_abs", int'(right), 10);

      clear_map(); set_rect(0, 1, 14, 15);
      send_frame(1'b0, -1, W * H, tl);
      wait_box(tl, "c2");
      check_eq("c2_left_abs", int'(left), 13);
      check_eq("c2_right_abs", int'(right), 15);

      clear_map();
      send_frame(1'b0, -1, W * H, tl);
      wait_box(tl, "c3");

      clear_map(); fg_map[3][6] = 1'b1;
      send_frame(1'b0, -1, W * H, tl);
      wait_box(tl, "c4");

      clear_map(); set_rect(2, 4, 5, 9);
      send_frame(1'b0, 3 * W + 7, 3 * W + 8, tl);
      @(negedge clk);
      check_eq("c5_sync_err", int'(sync_err), 1);
      wait_ready("c5_clear_len", 16);
      check_eq("c5_sync_pulse", int'(sync_err), 0);
      check_eq("c5_no_box", int'(box_valid), 0);
      send_frame(1'b0, -1, W * H, tl);
      wait_box(tl, "c5");

      for (int k = 0; k < 2; k++) begin
         random_map();
         send_frame(1'b1, -1, W * H, tl);
         wait_box(tl, $sformatf("rnd%0d", k));
      end

      clear_map(); set_rect(2, 4, 5, 9);
      send_frame(1'b0, -1, W * H, tl);
      wait_box(tl, "c1b");
      send_frame(1'b0, -1, 40, tl);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_coords", int'({top, bottom, left, right}), 0);
      check_eq("mid_rst_found", int'(box_found), 0);
      check_eq("mid_rst_ready", int'(in_ready), 0);
      @(negedge clk);
      rst = 1'b1;
      wait_ready("mid_rst_clear", 16);
      clear_map(); set_rect(0, 1, 14, 15);
      send_frame(1'b0, -1, W * H, tl);
      wait_box(tl, "c2b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
